// File: rtl/feature_pingpong_buf_if.sv
// Producer/consumer bus of the ping-pong feature buffer.
// Address fields are wide enough to carry an out-of-range index (DEPTH itself and above).
interface feature_pingpong_buf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1568
);
  localparam int ADDR_WIDTH = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_commit;
  logic                  wr_bank_free;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_valid;
  logic                  rd_release;
  logic                  rd_bank_valid;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input  wr_bank_free, rd_q, rd_valid, rd_bank_valid, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_bank_free, rd_q, rd_valid, rd_bank_valid, err
  );
endinterface

// File: rtl/feature_pingpong_buf.sv
// Two-bank ping-pong feature buffer between a producer layer and a dense-layer consumer.
// Defining FEATBUF_ERR_EN adds a sticky protocol-error flag on err; otherwise err is tied low.
module feature_pingpong_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1568,
  parameter int LAT        = 2
) (
  input logic                   clk,
  input logic                   reset,
  feature_pingpong_buf_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH + 1);
  localparam int MEM_AW     = $clog2(2 * DEPTH);

  logic [1:0]            full;
  logic [1:0]            full_next;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  wr_bank_free;
  logic                  rd_bank_valid;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_accept;
  logic                  commit_accept;
  logic                  release_accept;
  logic                  rd_accept;
  logic [MEM_AW-1:0]     wr_index;
  logic [MEM_AW-1:0]     rd_index;
  logic [DATA_WIDTH-1:0] mem [2*DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data [LAT];
  logic [LAT-1:0]        pipe_valid;
  logic [LAT-1:0]        pipe_oob;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_valid;

  assign wr_bank_free  = !full[wr_sel];
  assign rd_bank_valid = full[rd_sel];

  assign wr_in_range    = bus.wr_addr < ADDR_WIDTH'(DEPTH);
  assign rd_in_range    = bus.rd_addr < ADDR_WIDTH'(DEPTH);
  assign wr_accept      = bus.wr_en && wr_bank_free && wr_in_range && !reset;
  assign commit_accept  = bus.wr_commit && wr_bank_free;
  assign release_accept = bus.rd_release && rd_bank_valid;
  assign rd_accept      = bus.rd_en && rd_bank_valid && !reset;

  // Both banks share one RAM: bank 1 occupies the upper DEPTH entries.
  assign wr_index = (wr_sel ? MEM_AW'(DEPTH) : MEM_AW'(0)) + MEM_AW'(bus.wr_addr);
  assign rd_index = (rd_sel ? MEM_AW'(DEPTH) : MEM_AW'(0))
                  + (rd_in_range ? MEM_AW'(bus.rd_addr) : MEM_AW'(0));

  // Commit and release can never target the same bank, so both updates apply.
  always_comb begin
    full_next = full;
    if (commit_accept)  full_next[wr_sel] = 1'b1;
    if (release_accept) full_next[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full <= full_next;
      if (commit_accept)  wr_sel <= !wr_sel;
      if (release_accept) rd_sel <= !rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_index] <= wr_data_q();
  end

  function automatic logic [DATA_WIDTH-1:0] wr_data_q();
    return bus.wr_data;
  endfunction

  // Stage 0 is the RAM output register; later stages only add latency.
  always_ff @(posedge clk) begin
    if (rd_accept) pipe_data[0] <= mem[rd_index];
    for (int i = 1; i < LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_oob   <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_oob[0]   <= !rd_in_range;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_oob[i]   <= pipe_oob[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pipe_valid[LAT-1];
      if (pipe_valid[LAT-1]) rd_q <= pipe_oob[LAT-1] ? '0 : pipe_data[LAT-1];
    end
  end

  assign bus.wr_bank_free  = wr_bank_free;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.rd_q          = rd_q;
  assign bus.rd_valid      = rd_valid;

`ifdef FEATBUF_ERR_EN
  logic err_reg;
  logic protocol_violation;

  assign protocol_violation = ((bus.wr_en || bus.wr_commit) && !wr_bank_free)
                           || ((bus.rd_en || bus.rd_release) && !rd_bank_valid)
                           || (bus.wr_en && !wr_in_range)
                           || (bus.rd_en && !rd_in_range);

  always_ff @(posedge clk) begin
    if (reset)                   err_reg <= 1'b0;
    else if (protocol_violation) err_reg <= 1'b1;
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif
endmodule
